// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: opcodes, FSM state encoding and data width.
package alu_pkg;

    localparam int unsigned ALU_W = 16;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_MOVE  = 4'd3;
    localparam logic [3:0] OP_READ  = 4'd4;
    localparam logic [3:0] OP_WRITE = 4'd5;
    localparam logic [3:0] OP_JMP   = 4'd6;
    localparam logic [3:0] OP_ADD   = 4'd7;
    localparam logic [3:0] OP_ADD1  = 4'd8;
    localparam logic [3:0] OP_MUL   = 4'd9;
    localparam logic [3:0] OP_FLOOR = 4'd10;
    localparam logic [3:0] OP_SUB   = 4'd11;
    localparam logic [3:0] OP_EXP   = 4'd12;
    localparam logic [3:0] OP_ROOF  = 4'd13;
    localparam logic [3:0] OP_MOD   = 4'd14;
    localparam logic [3:0] OP_JMPZ  = 4'd15;

    typedef logic [2:0] sched_state_t;

    localparam sched_state_t S_IDLE    = 3'd0;
    localparam sched_state_t S_ISSUE   = 3'd1;
    localparam sched_state_t S_WAIT    = 3'd2;
    localparam sched_state_t S_M_ISSUE = 3'd3;
    localparam sched_state_t S_M_WAIT  = 3'd4;
    localparam sched_state_t S_I_ISSUE = 3'd5;
    localparam sched_state_t S_I_WAIT  = 3'd6;
    localparam sched_state_t S_RESP    = 3'd7;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MOD);
    endfunction

    // Ops that divide by operand B and must reject a zero divisor.
    function automatic logic needs_divisor(input logic [3:0] op);
        return (op == OP_FLOOR) || (op == OP_ROOF) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last winner loses the next tie.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic       grant_c
);

    logic last_grant;

    always_comb begin
        grant_c = valid[1];
        if (&valid) begin
            grant_c = ~last_grant;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant_c;
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Shares one registered ALU between two requesters, one op in flight,
// with pre-checked rejects and the FLOOR/MOD/ADD1 sequence for ROOF.
module alu_sched
    import alu_pkg::*;
#(
    parameter int unsigned LAT = 1,
    parameter int unsigned W   = ALU_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [3:0]   req_op0,
    input  logic [3:0]   req_op1,
    input  logic [W-1:0] req_a0,
    input  logic [W-1:0] req_a1,
    input  logic [W-1:0] req_b0,
    input  logic [W-1:0] req_b1,
    output logic [3:0]   alu_op,
    output logic [W-1:0] alu_in1,
    output logic [W-1:0] alu_in2,
    input  logic [W-1:0] alu_out,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [W-1:0] rsp_data,
    output logic         rsp_zero,
    output logic         rsp_err,
    output logic         busy
);

    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    sched_state_t state, state_n;

    logic         id_q, id_n;
    logic [3:0]   op_q, op_n;
    logic [W-1:0] a_q, a_n, b_q, b_n, q_q, q_n;
    logic [CW-1:0] cnt_q, cnt_n;

    logic [3:0]   alu_op_n;
    logic [W-1:0] alu_in1_n, alu_in2_n;
    logic         rsp_valid_n, rsp_id_n, rsp_zero_n, rsp_err_n;
    logic [W-1:0] rsp_data_n;

    logic         grant_c, accept_c;
    logic [3:0]   sel_op_c;
    logic [W-1:0] sel_a_c, sel_b_c;
    logic         done_c, done_err_c;
    logic [W-1:0] done_data_c;

    rr_arb2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .valid   (req_valid),
        .accept  (accept_c),
        .grant_c (grant_c)
    );

    // Ready is offered only in IDLE, and only to the arbiter's pick.
    always_comb begin
        req_ready = 2'b00;
        if ((state == S_IDLE) && !reset && (|req_valid)) begin
            req_ready = grant_c ? 2'b10 : 2'b01;
        end
    end

    assign accept_c = |(req_valid & req_ready);
    assign sel_op_c = grant_c ? req_op1 : req_op0;
    assign sel_a_c  = grant_c ? req_a1  : req_a0;
    assign sel_b_c  = grant_c ? req_b1  : req_b0;

    always_comb begin
        state_n     = state;
        id_n        = id_q;
        op_n        = op_q;
        a_n         = a_q;
        b_n         = b_q;
        q_n         = q_q;
        cnt_n       = cnt_q;
        alu_op_n    = OP_NOP;
        alu_in1_n   = '0;
        alu_in2_n   = '0;
        done_c      = 1'b0;
        done_err_c  = 1'b0;
        done_data_c = '0;
        rsp_valid_n = 1'b0;
        rsp_id_n    = 1'b0;
        rsp_data_n  = '0;
        rsp_zero_n  = 1'b0;
        rsp_err_n   = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    id_n = grant_c;
                    op_n = sel_op_c;
                    a_n  = sel_a_c;
                    b_n  = sel_b_c;
                    if (!is_alu_op(sel_op_c)) begin
                        done_c     = 1'b1;
                        done_err_c = 1'b1;
                    end else if (needs_divisor(sel_op_c) && (sel_b_c == '0)) begin
                        done_c     = 1'b1;
                        done_err_c = 1'b1;
                    end else if ((sel_op_c == OP_SUB) && (sel_a_c <= sel_b_c)) begin
                        // Equal operands answer zero directly; a < b is an underflow.
                        done_c     = 1'b1;
                        done_err_c = (sel_a_c != sel_b_c);
                    end else begin
                        state_n   = S_ISSUE;
                        alu_op_n  = (sel_op_c == OP_ROOF) ? OP_FLOOR : sel_op_c;
                        alu_in1_n = sel_a_c;
                        alu_in2_n = sel_b_c;
                    end
                end
            end
            S_ISSUE: begin
                state_n = S_WAIT;
                cnt_n   = CW'(LAT - 1);
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - CW'(1);
                end else if (op_q == OP_ROOF) begin
                    q_n       = alu_out;
                    state_n   = S_M_ISSUE;
                    alu_op_n  = OP_MOD;
                    alu_in1_n = a_q;
                    alu_in2_n = b_q;
                end else begin
                    done_c      = 1'b1;
                    done_data_c = alu_out;
                end
            end
            S_M_ISSUE: begin
                state_n = S_M_WAIT;
                cnt_n   = CW'(LAT - 1);
            end
            S_M_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - CW'(1);
                end else if (alu_out == '0) begin
                    done_c      = 1'b1;
                    done_data_c = q_q;
                end else begin
                    state_n   = S_I_ISSUE;
                    alu_op_n  = OP_ADD1;
                    alu_in1_n = q_q;
                end
            end
            S_I_ISSUE: begin
                state_n = S_I_WAIT;
                cnt_n   = CW'(LAT - 1);
            end
            S_I_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - CW'(1);
                end else begin
                    done_c      = 1'b1;
                    done_data_c = alu_out;
                end
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Response fields are staged so they appear during the RESP cycle only.
        if (done_c) begin
            state_n     = S_RESP;
            rsp_valid_n = 1'b1;
            rsp_id_n    = id_n;
            rsp_data_n  = done_err_c ? '0 : done_data_c;
            rsp_zero_n  = (rsp_data_n == '0);
            rsp_err_n   = done_err_c;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            id_q      <= 1'b0;
            op_q      <= OP_NOP;
            a_q       <= '0;
            b_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            alu_op    <= OP_NOP;
            alu_in1   <= '0;
            alu_in2   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            id_q      <= id_n;
            op_q      <= op_n;
            a_q       <= a_n;
            b_q       <= b_n;
            q_q       <= q_n;
            cnt_q     <= cnt_n;
            alu_op    <= alu_op_n;
            alu_in1   <= alu_in1_n;
            alu_in2   <= alu_in2_n;
            rsp_valid <= rsp_valid_n;
            rsp_id    <= rsp_id_n;
            rsp_data  <= rsp_data_n;
            rsp_zero  <= rsp_zero_n;
            rsp_err   <= rsp_err_n;
            busy      <= (state_n != S_IDLE);
        end
    end

endmodule

// File: doc/alu_sched.md
Name: alu_sched

Overview:
- Shares the single registered ALU between two requesters: R0 is the control-unit datapath and R1 is the auxiliary/address unit.
- Arbitrates round-robin and keeps at most one operation in flight.
- Sequences the ALU's multi-step ROOF macro-op (FLOOR, MOD, conditional ADD1).
- Resolves divide-by-zero, SUB equal/underflow and illegal opcodes without issuing to the ALU.
- Sits between the requesters and the ALU ports In_1/In_2/ALUOp/ALUOut.

Parameters:
- LAT, 1: edges from ALU sampling an op to alu_out being valid. Must be ≥ 1.
- W, 16: data width.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  2  per-requester request valid; bit i belongs to Ri
- req_ready  out  2  per-requester accept strobe
- req_op0, req_op1  in  4  opcode, using the ALU encoding (7 to 14 legal)
- req_a0, req_a1  in  W  operand A (In_1)
- req_b0, req_b1  in  W  operand B (In_2)
- alu_op  out  4  drives ALUOp
- alu_in1  out  W  drives In_1
- alu_in2  out  W  drives In_2
- alu_out  in  W  ALUOut
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_id  out  1  requester that owns the response
- rsp_data  out  W  result
- rsp_zero  out  1  rsp_data == 0
- rsp_err  out  1  operation rejected; rsp_data = 0
- busy  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE; last_grant 1 (so R0 wins the first tie); all rsp_* 0; req_ready 0; alu_op 0 (NOP); alu_in1/alu_in2 0; busy 0. A reset mid-operation abandons the op and emits no response.
- States:
  - IDLE, ISSUE, WAIT, M_ISSUE, M_WAIT, I_ISSUE, I_WAIT, RESP.
  - alu_op is non-zero only in *_ISSUE states, so the ALU sees NOP, and holds ALUOut, at all other times.
- Arbitration (IDLE only):
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the one that is not last_grant.
  - req_ready[g] is asserted combinationally in IDLE for the granted index only, so the accept is req_valid[g] & req_ready[g].
  - On accept: latch id, op, a and b, and set last_grant = g.
- Pre-check at accept (no ALU issue); the next state is RESP with:
  - op outside 7..14: rsp_err = 1.
  - op in {10, 13, 14} and b == 0: rsp_err = 1.
  - op 11 and a == b: rsp_data = 0, rsp_zero = 1, rsp_err = 0.
  - op 11 and a < b: rsp_err = 1 (underflow).
- Single-step ops (7, 8, 9, 10, 11-valid, 12, 14):
  - ISSUE drives alu_op = op, alu_in1 = a, alu_in2 = b for one cycle.
  - WAIT runs a down-counter of LAT cycles, then captures alu_out into a result register and goes to RESP.
- ROOF (13):
  - ISSUE op 10 (FLOOR), WAIT, capture q.
  - M_ISSUE op 14 (MOD) with the same a and b, M_WAIT, capture r.
  - If r == 0: result = q, go to RESP.
  - Otherwise: I_ISSUE op 8 with in1 = q, I_WAIT, capture q+1, go to RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle, with rsp_id, rsp_data, rsp_zero and rsp_err from registers. Then go to IDLE.
  - All rsp_* fields are 0 when rsp_valid = 0.
- Latency, counted from the accept edge to the cycle in which rsp_valid is high:
  - pre-check reject: 1 edge
  - single-step: LAT+2 edges
  - ROOF with r == 0: 2·(LAT+1)+1 edges
  - ROOF with r != 0: 3·(LAT+1)+1 edges
- Throughput: one op in flight. req_ready stays 0 from the accept edge until IDLE is re-entered.
- Width rules: results are truncated to W bits (MUL keeps the low W bits; ADD wraps modulo 2^W). rsp_zero is computed on the truncated value.
- Simultaneous events:
  - A request arriving during busy waits; its req_valid must be held by the requester.
  - A request deasserted before being accepted is simply not served.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_NOP … OP_JMPZ (0..15)
  - the state enum for alu_sched
  - the W default
  - an is_alu_op(op) function for the 7..14 range
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter with a last_grant register and an update-on-accept input.

Test Plan:
- R0 ADD a=5, b=7, LAT=1 → accept; ALU sees alu_op=7 for one cycle; rsp_valid 3 edges after accept with id=0, data=12, zero=0, err=0.
- Both requesters valid from reset: R0 MUL 300·300, R1 SUB 9−9 → R0 granted first with data=0x5F90 (low 16 bits of 90000). R1 then granted, with no ALU issue: data=0, zero=1.
- R1 ROOF a=7, b=2 → ALU ops 10, 14, 8 in sequence; data=4 after 7 edges. Then ROOF a=8, b=2 → ops 10, 14 only; data=4 after 5 edges.
- FLOOR a=9, b=0 and opcode 3 → each gives rsp_err=1, data=0 one edge after accept; alu_op stays 0 throughout.
- SUB a=3, b=5 → err=1. ADD a=0xFFFF, b=1 → data=0, zero=1.
- Reset asserted in M_WAIT of a ROOF → next cycle IDLE; no rsp_valid; alu_op=0. A new R0 ADD 1+1 then returns data=2.
